audio_i2c_target: RTL and testbench

I2C target (responder) with a small 8-bit register file, the far end of the bit-banged SCL/SDA PIO initiator driven by the NIOS II. It decodes START/STOP, matches a 7-bit device address, ACKs, and supports register-pointer writes, burst writes and burst reads with auto-increment. It stands in for the audio codec's control port in on-chip loopback and simulation. Local logic can observe register writes and read the file.

---
 rtl/audio_i2c_pkg.sv | 24 ++
 rtl/audio_i2c_target_sync.sv | 34 +++
 rtl/audio_i2c_target.sv | 223 ++++++++++++++++++++++
 tb/tb_audio_i2c_target.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2c_pkg.sv
// Shared types and bus constants for the audio codec I2C target.
package audio_i2c_pkg;

  // Protocol phases of the target, from START through the byte/ACK cycles.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2c_state_e;

  // SDA level seen during the ninth (acknowledge) clock.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Value of the address byte LSB that requests a read.
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/audio_i2c_target_sync.sv
// Two-flop synchronizer plus history flop for one raw bus line.
// Produces the synchronized level and single-cycle rise/fall pulses.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic hist_p2;

  // Resample the line into clk; reset to the idle-high bus level so that
  // leaving reset never fabricates an edge on a released line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist_p2 <= 1'b1;
    end else begin
      meta_p0 <= line_i;
      sync_p1 <= meta_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~hist_p2;
  assign fall  = ~sync_p1 & hist_p2;

endmodule

// File: rtl/audio_i2c_target.sv
// I2C target with a small byte-wide register file. Supports pointer
// writes, burst writes and burst reads with pointer auto-increment.
module audio_i2c_target
  import audio_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         AW       = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] loc_addr,
  output logic [7:0]    loc_rdata
);

  localparam int            NREG    = 2 ** AW;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (scl_i),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (sda_i),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // Bus conditions: SDA may only move while SCL is low, except for these.
  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  i2c_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          mack_q, mack_d;
  logic          busy_d;
  logic          sda_oe_d;
  logic          wr_en;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic [7:0]    regs [NREG];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state, shifter, pointer and SDA drive decisions.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    busy_d    = busy;
    sda_oe_d  = sda_oe;
    wr_en     = 1'b0;
    rx_byte   = {shift_q[6:0], sda_lvl};
    rd_byte   = regs[ptr_q];

    if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_cond) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                  state_d = ST_ADDR_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = ST_REG_ACK;
              end else begin
                wr_en   = 1'b1;
                ptr_d   = ptr_q + PTR_ONE;
                state_d = ST_WDATA_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // sda_oe doubles as the ACK phase flag: the first fall pulls SDA
        // low, the following fall ends the acknowledge clock.
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                shift_d  = rd_byte;
                ptr_d    = ptr_q + PTR_ONE;
                sda_oe_d = ~rd_byte[7];
                state_d  = ST_RDATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        // Count initiator sampling rises; present the next bit on each fall.
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              state_d  = ST_RACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        // Initiator ACK continues the burst; NACK parks with busy still set.
        ST_RACK: begin
          if (scl_rise) begin
            mack_d = (sda_lvl == I2C_ACK);
            if (sda_lvl == I2C_NACK) state_d = ST_IDLE;
          end else if (scl_fall && mack_q) begin
            shift_d   = rd_byte;
            ptr_d     = ptr_q + PTR_ONE;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            mack_d    = 1'b0;
            state_d   = ST_RDATA;
          end
        end

        ST_IDLE: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output registers; reset drops SDA immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      busy      <= busy_d;
      sda_oe    <= sda_oe_d;
      wr_stb    <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr_q;
        wr_data <= rx_byte;
      end
    end
  end

  // Register file write port and registered local read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      loc_rdata <= '0;
    end else begin
      if (wr_en) regs[ptr_q] <= rx_byte;
      loc_rdata <= regs[loc_addr];
    end
  end

endmodule

// File: tb/tb_audio_i2c_target.sv
// Bus-level bench for audio_i2c_target: a bit-banged initiator drives
// SCL/SDA, a reference model predicts ACKs, read bytes and write strobes,
// and a monitor pops the expectations as the DUT produces responses.
module tb_audio_i2c_target;

  localparam int H = 10;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_addr, loc_addr;
  logic [7:0] wr_data, loc_rdata;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  audio_i2c_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [7:0] mregs [16];
  int         mptr;

  // Scoreboard queues.
  int exp_wr_q[$];
  int exp_rd_q[$];
  int exp_ack_q[$];
  int obs_rd_q[$];
  int obs_ack_q[$];
  logic [7:0] wbytes[$];

  int   oe_cnt = 0;
  logic oe_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- bit-level initiator ----------------
  task automatic send_bit(input logic b);
    wait_clk(2); sda_m = b; wait_clk(H - 2);
    scl_m = 1'b1; wait_clk(H); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(2); sda_m = 1'b1; wait_clk(H - 2);
    scl_m = 1'b1; wait_clk(H / 2); b = sda_i; wait_clk(H - H / 2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2); sda_m = 1'b0; wait_clk(H - 2);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    obs_ack_q.push_back(int'(a));
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] b;
    logic       x;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(x);
      b = {b[6:0], x};
    end
    send_bit(nack);
    obs_rd_q.push_back(int'(b));
  endtask

  // ---------------- transaction level with model ----------------
  task automatic tx_write(input logic [7:0] p);
    for (int i = 0; i < wbytes.size() + 2; i++) exp_ack_q.push_back(0);
    mptr = p % 16;
    foreach (wbytes[i]) begin
      exp_wr_q.push_back(mptr * 256 + wbytes[i]);
      mregs[mptr] = wbytes[i];
      mptr = (mptr + 1) % 16;
    end
    i2c_start();
    write_byte(8'h34);
    chk("busy_after_match", int'(busy), 1);
    write_byte(p);
    foreach (wbytes[i]) write_byte(wbytes[i]);
    i2c_stop();
    chk("busy_after_stop", int'(busy), 0);
  endtask

  task automatic tx_read(input logic set_ptr, input logic [7:0] p, input int n);
    exp_ack_q.push_back(0);
    if (set_ptr) begin
      exp_ack_q.push_back(0);
      exp_ack_q.push_back(0);
      mptr = p % 16;
    end
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(int'(mregs[mptr]));
      mptr = (mptr + 1) % 16;
    end
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h34);
      write_byte(p);
      i2c_start();
    end
    write_byte(8'h35);
    chk("busy_in_read", int'(busy), 1);
    for (int i = 0; i < n; i++) read_byte(i == n - 1);
    i2c_stop();
    chk("busy_after_stop", int'(busy), 0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      loc_addr = i[3:0];
      wait_clk(2);
      chk($sformatf("loc_rdata[%0d]", i), int'(loc_rdata), int'(mregs[i]));
    end
  endtask

  // ---------------- monitor ----------------
  int m_e, m_o;
  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) chk("wr_stb_unexpected", 1, 0);
      else begin
        m_e = exp_wr_q.pop_front();
        chk("wr_addr", int'(wr_addr), m_e / 256);
        chk("wr_data", int'(wr_data), m_e % 256);
      end
    end
    if (obs_ack_q.size() > 0) begin
      m_o = obs_ack_q.pop_front();
      if (exp_ack_q.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        m_e = exp_ack_q.pop_front();
        chk("ack_bit", m_o, m_e);
      end
    end
    if (obs_rd_q.size() > 0) begin
      m_o = obs_rd_q.pop_front();
      if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        m_e = exp_rd_q.pop_front();
        chk("rd_byte", m_o, m_e);
      end
    end
  end

  always @(posedge clk) begin
    if (sda_oe && !oe_prev) oe_cnt++;
    oe_prev = sda_oe;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         oe_snap;
    int         kind, n;
    logic [7:0] p, d;

    scl_m = 1'b1; sda_m = 1'b1; loc_addr = '0; reset_n = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mptr = 0;
    wait_clk(4);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_stb", int'(wr_stb), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_loc_rdata", int'(loc_rdata), 0);
    reset_n = 1'b1;
    wait_clk(4);

    // Burst write from pointer 3.
    wbytes = '{8'hA5, 8'h5A};
    tx_write(8'h03);
    loc_addr = 4'd4; wait_clk(2);
    chk("loc_rdata_addr4", int'(loc_rdata), 8'h5A);

    // Pointer write, repeated START, two-byte read.
    tx_read(1'b1, 8'h03, 2);

    // Wrong device address: never acknowledged, nothing written.
    oe_snap = oe_cnt;
    exp_ack_q.push_back(1);
    exp_ack_q.push_back(1);
    i2c_start();
    write_byte(8'h36);
    chk("busy_bad_addr", int'(busy), 0);
    write_byte(8'h55);
    i2c_stop();
    chk("sda_oe_bad_addr", oe_cnt - oe_snap, 0);

    // Pointer wraps from 15 to 0.
    wbytes = '{8'h11, 8'h22};
    tx_write(8'h0F);
    check_regs();

    // STOP after five data bits discards the byte.
    exp_ack_q.push_back(0);
    exp_ack_q.push_back(0);
    mptr = 7;
    i2c_start();
    write_byte(8'h34);
    write_byte(8'h07);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_wr", exp_wr_q.size(), 0);
    wbytes = '{8'h3C};
    tx_write(8'h08);

    // Reset while the target drives a 0 data bit.
    wbytes = '{8'h0F};
    tx_write(8'h02);
    exp_ack_q.push_back(0);
    exp_ack_q.push_back(0);
    exp_ack_q.push_back(0);
    i2c_start();
    write_byte(8'h34);
    write_byte(8'h02);
    i2c_start();
    write_byte(8'h35);
    wait_clk(6);
    chk("drive_zero_before_reset", int'(sda_oe), 1);
    #3 reset_n = 1'b0;
    #1 chk("sda_oe_async_reset", int'(sda_oe), 0);
    wait_clk(3);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mptr = 0;
    i2c_stop();
    chk("busy_after_reset", int'(busy), 0);
    check_regs();
    wbytes = '{8'h77};
    tx_write(8'h00);

    // Randomized transactions against the model.
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      p    = 8'($urandom);
      if (kind == 0) begin
        wbytes.delete();
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          wbytes.push_back(d);
        end
        tx_write(p);
      end else begin
        tx_read(kind == 1, p, n);
      end
    end
    check_regs();

    wait_clk(4);
    chk("exp_wr_drained", exp_wr_q.size(), 0);
    chk("exp_rd_drained", exp_rd_q.size(), 0);
    chk("exp_ack_drained", exp_ack_q.size(), 0);
    chk("obs_drained", obs_rd_q.size() + obs_ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
